sn74xx163: RTL and testbench

Synchronous presettable binary counter modelled on the 74163: synchronous clear, synchronous parallel load, count enables ENP/ENT, and ripple-carry output. It sits directly upstream of the SN74XX153 dual 4-to-1 mux in the library and generates its select and strobe sequence: q[1:0] drives sel, q[2] drives str. The block is parameterised as a cascade of 4-bit stages. Internally it chains stage RCO into the next stage's ENT, exactly as discrete 74163s are wired on a board.

---
 rtl/sn74xx163_if.sv | 37 +++
 rtl/sn74xx163.sv | 59 +++++
 tb/tb_sn74xx163.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sn74xx163_if.sv
// Counter bus for sn74xx163: parallel load, count enables, load data and the
// counter outputs. Clock and clear stay plain ports on the counter itself.
//   load  - active-low synchronous parallel load
//   enp   - count enable P (gates counting only)
//   ent   - count enable T (gates counting and rco)
//   d     - parallel load data, d[3:0] is the least significant stage
//   q     - counter value, q[0] is the LSB
//   rco   - ripple carry out, ent & (q == all ones)
// master: the block driving the controls; slave: the counter.
interface sn74xx163_if #(
  parameter int unsigned STAGES = 1
);
  logic                    load;
  logic                    enp;
  logic                    ent;
  logic [4*STAGES-1:0]     d;
  logic [4*STAGES-1:0]     q;
  logic                    rco;

  modport master (
    output load,
    output enp,
    output ent,
    output d,
    input  q,
    input  rco
  );

  modport slave (
    input  load,
    input  enp,
    input  ent,
    input  d,
    output q,
    output rco
  );
endinterface

// File: rtl/sn74xx163.sv
// Synchronous presettable binary counter in the style of the 74163, built as a
// cascade of STAGES 4-bit stages (width 4*STAGES, legal STAGES 1..8).
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous active-low clear, highest priority
//   bus  - sn74xx163_if slave: load, enp, ent, d in; q, rco out
// Priority per edge: clear, then load (ignores enables), then count when
// enp & ent, otherwise hold. rco is combinational from ent and q.
module sn74xx163 #(
  parameter int unsigned STAGES = 1
) (
  input logic        clk,
  input logic        clr,
  sn74xx163_if.slave bus
);

  logic [STAGES-1:0][3:0] cnt_q;
  logic [STAGES-1:0][3:0] cnt_d;
  // ent seen by each stage: ent for stage 0, previous stage's rco above it.
  logic [STAGES-1:0]      ent_stage;
  logic                   carry;

  // Carry chain as on a board of discrete parts: each stage's rco feeds the
  // next stage's ent. A running accumulator keeps the chain free of a
  // self-referencing vector.
  always_comb begin
    carry = bus.ent;
    for (int k = 0; k < STAGES; k++) begin
      ent_stage[k] = carry;
      carry        = carry & (cnt_q[k] == 4'hF);
    end
  end

  // Load takes every stage at once and ignores the enables; otherwise a stage
  // steps when enp is high and its own ent is high, so an upper stage steps
  // on the same edge the stages below it wrap F->0.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < STAGES; k++) begin
      if (!bus.load) begin
        cnt_d[k] = bus.d[4*k +: 4];
      end else if (bus.enp && ent_stage[k]) begin
        cnt_d[k] = cnt_q[k] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.q   = cnt_q;
  assign bus.rco = carry;

endmodule

// File: tb/tb_sn74xx163.sv
module tb_sn74xx163;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr1;
  logic clr2;

  sn74xx163_if #(.STAGES(1)) bus1 ();
  sn74xx163_if #(.STAGES(2)) bus2 ();

  sn74xx163 #(.STAGES(1)) dut1 (
    .clk (clk),
    .clr (clr1),
    .bus (bus1)
  );

  sn74xx163 #(.STAGES(2)) dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (bus2)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic       enp;
    logic       ent;
    logic [7:0] d;
    logic [7:0] q;
    logic       rco;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];
  int   checks   = 0;
  int   failures = 0;

  // 74153 stand-in: a=3, b=2, c=1, d=0, strobe high forces 00.
  logic [1:0] mux_exp [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  function automatic logic [1:0] mux153(input logic [1:0] sel, input logic str);
    if (str) return 2'b00;
    case (sel)
      2'd0:    return 2'd3;
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic vec_t mk(input logic clr, input logic load, input logic enp,
                              input logic ent, input logic [7:0] d, input logic [7:0] q,
                              input logic rco);
    vec_t v;
    v.clr  = clr;
    v.load = load;
    v.enp  = enp;
    v.ent  = ent;
    v.d    = d;
    v.q    = q;
    v.rco  = rco;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic apply1(input vec_t v, input string name);
    clr1      = v.clr;
    bus1.load = v.load;
    bus1.enp  = v.enp;
    bus1.ent  = v.ent;
    bus1.d    = v.d[3:0];
    @(posedge clk);
    #1;
    check({name, " q"}, {4'h0, bus1.q}, v.q);
    check({name, " rco"}, {7'h0, bus1.rco}, {7'h0, v.rco});
  endtask

  task automatic apply2(input vec_t v, input string name);
    clr2      = v.clr;
    bus2.load = v.load;
    bus2.enp  = v.enp;
    bus2.ent  = v.ent;
    bus2.d    = v.d;
    @(posedge clk);
    #1;
    check({name, " q"}, bus2.q, v.q);
    check({name, " rco"}, {7'h0, bus2.rco}, {7'h0, v.rco});
  endtask

  initial begin
    clr1 = 1'b0; bus1.load = 1'b1; bus1.enp = 1'b0; bus1.ent = 1'b0; bus1.d = '0;
    clr2 = 1'b0; bus2.load = 1'b1; bus2.enp = 1'b0; bus2.ent = 1'b0; bus2.d = '0;

    // STAGES=1: clear, then free run through a wrap.
    t1.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0));
    for (int i = 1; i <= 17; i++) begin
      t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'(i % 16), (i % 16) == 15));
    end
    // Count on to 5, then load priority and clear-over-load.
    t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h02, 1'b0));
    t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h03, 1'b0));
    t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h04, 1'b0));
    t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05, 1'b0));
    t1.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 8'h0A, 1'b0));
    t1.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h0B, 1'b0));
    t1.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 8'h00, 1'b0));
    // Load F with enp low, then hold with enp=0, ent=1.
    t1.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b1));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b1));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b1));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b1));

    // STAGES=2: cascade, wrap at FF, ent gating, reset mid-count.
    t2.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0));
    t2.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h0E, 8'h0E, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h0F, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0));
    t2.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0));
    t2.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b0));
    t2.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 8'h34, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h35, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h36, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h37, 1'b0));
    t2.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0));
    t2.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1));
    t2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0));

    for (int i = 0; i < t1.size(); i++) begin
      apply1(t1[i], $sformatf("s1 step%0d", i));
      // First eight steps walk q through 0..7 into the mux.
      if (i < 8) begin
        check($sformatf("s1 mux q=%0d", i), {6'h0, mux153(bus1.q[1:0], bus1.q[2])},
              {6'h0, mux_exp[i]});
      end
    end

    // q=F, enp=0: rco follows ent with no clock edge.
    bus1.ent = 1'b0;
    #1;
    check("s1 ent drop rco", {7'h0, bus1.rco}, 8'h00);
    check("s1 ent drop q", {4'h0, bus1.q}, 8'h0F);
    bus1.ent = 1'b1;
    #1;
    check("s1 ent raise rco", {7'h0, bus1.rco}, 8'h01);

    apply1(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0), "s1 wrap");
    apply1(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1), "s1 load F");
    apply1(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 8'h03, 1'b0), "s1 load at ones");

    for (int i = 0; i < t2.size(); i++) begin
      apply2(t2[i], $sformatf("s2 step%0d", i));
    end

    // q=FF, ent was low: raising ent brings rco up combinationally.
    bus2.enp = 1'b0;
    bus2.ent = 1'b1;
    #1;
    check("s2 ent raise rco", {7'h0, bus2.rco}, 8'h01);
    check("s2 ent raise q", bus2.q, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
